// File: rtl/card_dealer.sv
// card_dealer: deals unique cards from a 52-card deck, one valid/ready beat per card, on round-advance pulses.
// Optional macro DEALER_BURN_EN: burn one hidden card before the flop, turn and river.
module card_dealer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       reset_d,
  input  logic       round_pulse,
  input  logic [2:0] round,
  input  logic       card_ready,
  output logic       card_valid,
  output logic [5:0] card,
  output logic [2:0] card_slot,
  output logic       busy,
  output logic       round_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;
`ifdef DEALER_BURN_EN
  localparam logic BURN_EN = 1'b1;
`else
  localparam logic BURN_EN = 1'b0;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    if (v[0]) begin
      r = (v >> 1) ^ TAPS;
    end else begin
      r = v >> 1;
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [1:0]           need_q, need_d;
  logic [2:0]           slot_q, slot_d;
  logic                 burn_q, burn_d;
  logic [5:0]           card_q, card_d;
  logic [2:0]           card_slot_q, card_slot_d;
  logic                 card_valid_q, card_valid_d;
  logic                 busy_q, busy_d;
  logic                 round_done_q, round_done_d;

  logic [5:0]           cand_s;
  logic                 cand_ok_s;
  logic [63:0]          used_ext_s;

  // Zero-extended bitmap so out-of-deck candidates can be indexed safely.
  assign used_ext_s = 64'(used_q);

  // Next-state and datapath for the dealing FSM.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    used_d       = used_q;
    need_d       = need_q;
    slot_d       = slot_q;
    burn_d       = burn_q;
    card_d       = card_q;
    card_slot_d  = card_slot_q;
    card_valid_d = card_valid_q;
    busy_d       = busy_q;
    round_done_d = 1'b0;
    cand_s       = lfsr_q[5:0];
    cand_ok_s    = (32'(cand_s) < DECK_SIZE) && !used_ext_s[cand_s];

    case (state_q)
      IDLE: begin
        if (round_pulse) begin
          case (round)
            3'd0: begin
              used_d  = '0;
              need_d  = 2'd2;
              slot_d  = 3'd0;
              burn_d  = 1'b0;
              busy_d  = 1'b1;
              state_d = DRAW;
            end
            3'd1: begin
              need_d  = 2'd3;
              slot_d  = 3'd2;
              burn_d  = BURN_EN;
              busy_d  = 1'b1;
              state_d = DRAW;
            end
            3'd2: begin
              need_d  = 2'd1;
              slot_d  = 3'd5;
              burn_d  = BURN_EN;
              busy_d  = 1'b1;
              state_d = DRAW;
            end
            3'd3: begin
              need_d  = 2'd1;
              slot_d  = 3'd6;
              burn_d  = BURN_EN;
              busy_d  = 1'b1;
              state_d = DRAW;
            end
            3'd4: begin
              busy_d  = 1'b1;
              state_d = DONE;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      DRAW: begin
        if (cand_ok_s) begin
          for (int i = 0; i < int'(DECK_SIZE); i++) begin
            if (32'(cand_s) == i) begin
              used_d[i] = 1'b1;
            end else begin
              used_d[i] = used_q[i];
            end
          end
          // A burned card is consumed from the deck but never shown.
          if (burn_q) begin
            burn_d  = 1'b0;
            state_d = DRAW;
          end else begin
            card_d       = cand_s;
            card_slot_d  = slot_q;
            card_valid_d = 1'b1;
            state_d      = PRESENT;
          end
        end else begin
          state_d = DRAW;
        end
      end

      PRESENT: begin
        if (card_valid_q && card_ready) begin
          card_valid_d = 1'b0;
          slot_d       = slot_q + 3'd1;
          need_d       = need_q - 2'd1;
          if (need_q == 2'd1) begin
            state_d = DONE;
          end else begin
            state_d = DRAW;
          end
        end else begin
          state_d = PRESENT;
        end
      end

      DONE: begin
        round_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; the LFSR free-runs in every state.
  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED_EFF;
      used_q       <= '0;
      need_q       <= 2'd0;
      slot_q       <= 3'd0;
      burn_q       <= 1'b0;
      card_q       <= 6'd0;
      card_slot_q  <= 3'd0;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      used_q       <= used_d;
      need_q       <= need_d;
      slot_q       <= slot_d;
      burn_q       <= burn_d;
      card_q       <= card_d;
      card_slot_q  <= card_slot_d;
      card_valid_q <= card_valid_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
    end
  end

  assign card_valid = card_valid_q;
  assign card       = card_q;
  assign card_slot  = card_slot_q;
  assign busy       = busy_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: vector table of rounds plus hand-written reset, stall and drop sequences.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset_d = 1'b1;
  logic       round_pulse = 1'b0;
  logic [2:0] round = 3'd0;
  logic       card_ready = 1'b1;
  logic       card_valid;
  logic [5:0] card;
  logic [2:0] card_slot;
  logic       busy;
  logic       round_done;

  card_dealer dut (
    .clk        (clk),
    .reset_d    (reset_d),
    .round_pulse(round_pulse),
    .round      (round),
    .card_ready (card_ready),
    .card_valid (card_valid),
    .card       (card),
    .card_slot  (card_slot),
    .busy       (busy),
    .round_done (round_done)
  );

  always #5 clk = ~clk;

`ifdef DEALER_BURN_EN
  localparam int EXP_USED = 10;
`else
  localparam int EXP_USED = 7;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  logic [2:0]  exp_q[$];
  logic [63:0] bench_used = 64'd0;
  logic        prev_valid = 1'b0;

  // Reference Galois LFSR (x^16+x^14+x^13+x^11+1, right-shifting).
  function automatic logic [15:0] m_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_prev = 16'hACE1;

  always @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_next(m_lfsr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, req);
    end
  endtask

  // Output monitor: new cards checked against the LFSR model and deck, beats popped from the scoreboard.
  always @(negedge clk) begin
    logic [2:0] es;
    if (reset_d) begin
      prev_valid = 1'b0;
    end else begin
      if (card_valid && !prev_valid) begin
        check("card_vs_lfsr", 32'(card), 32'(m_prev[5:0]));
        n_cmp++;
        if (card > 6'd51 || bench_used[card]) begin
          n_err++;
          $display("FAIL card_unique: got card %0d, wanted unused code below 52", card);
        end else begin
          bench_used[card] = 1'b1;
        end
      end
      if (card_valid && card_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got beat at slot %0d, wanted none", card_slot);
        end else begin
          es = exp_q.pop_front();
          check("beat_slot", 32'(card_slot), 32'(es));
        end
      end
      if (round_done) done_cnt++;
      prev_valid = card_valid;
    end
  end

  task automatic pulse(input logic [2:0] r);
    @(posedge clk);
    #1;
    if (r == 3'd0 && !busy) bench_used = 64'd0;
    round = r;
    round_pulse = 1'b1;
    @(posedge clk);
    #1;
    round_pulse = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (round_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] rnd;
    int         beats;
    logic [2:0] slot0;
    int         dones;
  } vec_t;

  vec_t vecs[8];
  logic [5:0] held_card;
  logic [2:0] held_slot;
  bit         seen;

  initial begin
    vecs[0] = '{3'd1, 3, 3'd2, 1};
    vecs[1] = '{3'd0, 2, 3'd0, 1};
    vecs[2] = '{3'd1, 3, 3'd2, 1};
    vecs[3] = '{3'd2, 1, 3'd5, 1};
    vecs[4] = '{3'd3, 1, 3'd6, 1};
    vecs[5] = '{3'd4, 0, 3'd0, 1};
    vecs[6] = '{3'd5, 0, 3'd0, 0};
    vecs[7] = '{3'd7, 0, 3'd0, 0};

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(card_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_d = 1'b0;
    check("rst_lfsr_seed", 32'(dut.lfsr_q), 32'hACE1);
    @(posedge clk);
    #1;
    check("lfsr_first_step", 32'(dut.lfsr_q), 32'(m_next(16'hACE1)));

    // Reset asserted while a card is being presented.
    card_ready = 1'b0;
    pulse(3'd1);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (card_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrun_valid_seen", 32'(seen), 32'd1);
    #2;
    reset_d = 1'b1;
    #1;
    check("midrst_valid", 32'(card_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(round_done), 32'd0);
    check("midrst_card", 32'(card), 32'd0);
    check("midrst_slot", 32'(card_slot), 32'd0);
    @(posedge clk);
    #1;
    reset_d = 1'b0;
    bench_used = 64'd0;
    card_ready = 1'b1;
    check("midrst_lfsr_seed", 32'(dut.lfsr_q), 32'hACE1);

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      beat_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < vecs[v].beats; k++) exp_q.push_back(vecs[v].slot0 + 3'(k));
      pulse(vecs[v].rnd);
      if (vecs[v].dones > 0) begin
        wait_done(400, "vec");
      end else begin
        repeat (20) @(negedge clk);
      end
      check("vec_beats", 32'(beat_cnt), 32'(vecs[v].beats));
      check("vec_dones", 32'(done_cnt), 32'(vecs[v].dones));
      check("vec_queue_left", 32'(exp_q.size()), 32'd0);
      check("vec_busy_after", 32'(busy), 32'd0);
    end
    check("used_bits_full_hand", 32'($countones(dut.used_q)), 32'(EXP_USED));

    // Tallyup: round_done two cycles after the pulse, no beats.
    beat_cnt = 0;
    pulse(3'd4);
    @(negedge clk);
    check("tally_busy", 32'(busy), 32'd1);
    check("tally_done_early", 32'(round_done), 32'd0);
    @(negedge clk);
    check("tally_done", 32'(round_done), 32'd1);
    check("tally_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    check("tally_done_single", 32'(round_done), 32'd0);
    check("tally_beats", 32'(beat_cnt), 32'd0);

    // Consumer stall during the flop.
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    pulse(3'd0);
    wait_done(400, "stall_pre");
    beat_cnt = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back(3'd2 + 3'(k));
    pulse(3'd1);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (card_valid && card_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_first_beat", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    card_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (card_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_second_valid", 32'(seen), 32'd1);
    held_card = card;
    held_slot = card_slot;
    check("stall_slot", 32'(held_slot), 32'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_hold", 32'({card_valid, card, card_slot}), 32'({1'b1, held_card, held_slot}));
    end
    check("stall_beats_held", 32'(beat_cnt), 32'd1);
    @(posedge clk);
    #1;
    card_ready = 1'b1;
    wait_done(400, "stall");
    check("stall_beats", 32'(beat_cnt), 32'd3);
    check("stall_queue_left", 32'(exp_q.size()), 32'd0);

    // Pulse while busy is dropped.
    beat_cnt = 0;
    done_cnt = 0;
    exp_q.push_back(3'd5);
    pulse(3'd2);
    pulse(3'd0);
    wait_done(400, "drop");
    repeat (20) @(negedge clk);
    check("drop_beats", 32'(beat_cnt), 32'd1);
    check("drop_dones", 32'(done_cnt), 32'd1);
    check("drop_queue_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, wanted finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
